// File: rtl/legv8_pkg.sv
// LEGv8 opcode set, field-range limits and a range helper shared by the
// instruction encoder and anything that decodes what it produces.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_B    = 4'd2,
    OP_B_LT = 4'd3,
    OP_CBZ  = 4'd4,
    OP_LDUR = 4'd5,
    OP_LSL  = 4'd6,
    OP_LSR  = 4'd7,
    OP_MUL  = 4'd8,
    OP_STUR = 4'd9,
    OP_SUBS = 4'd10
  } legv8_op_e;

  localparam logic [10:0] OPC_ADDS  = 11'h558;
  localparam logic [10:0] OPC_SUBS  = 11'h758;
  localparam logic [10:0] OPC_LSL   = 11'h69B;
  localparam logic [10:0] OPC_LSR   = 11'h69A;
  localparam logic [10:0] OPC_MUL   = 11'h4D8;
  localparam logic [10:0] OPC_LDUR  = 11'h7C2;
  localparam logic [10:0] OPC_STUR  = 11'h7C0;
  localparam logic [9:0]  OPC_ADDI  = 10'h244;
  localparam logic [7:0]  OPC_CBZ   = 8'hB4;
  localparam logic [7:0]  OPC_BCOND = 8'h54;
  localparam logic [5:0]  OPC_B     = 6'h05;
  localparam logic [4:0]  COND_LT   = 5'h0B;
  localparam logic [5:0]  MUL_SHAMT = 6'h1F;

  localparam int IMM12_MAX = 4095;
  localparam int D_MIN     = -256;
  localparam int D_MAX     = 255;
  localparam int CB_MIN    = -(1 << 18);
  localparam int CB_MAX    = (1 << 18) - 1;
  localparam int B_MIN     = -(1 << 25);
  localparam int B_MAX     = (1 << 25) - 1;

  function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request stream into the encoder plus its instruction-memory write port.
interface instr_encoder_if #(parameter int ADDR_W = 10);
  logic                op_valid;
  logic                op_ready;
  logic                op_last;
  logic [3:0]          op_sel;
  logic [4:0]          rd;
  logic [4:0]          rn;
  logic [4:0]          rm;
  logic signed [31:0]  imm;
  logic [5:0]          shamt;
  logic                imem_we;
  logic                imem_ready;
  logic [ADDR_W-1:0]   imem_addr;
  logic [31:0]         imem_wdata;

  modport master (
    output op_valid, op_last, op_sel, rd, rn, rm, imm, shamt, imem_ready,
    input  op_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  op_valid, op_last, op_sel, rd, rn, rm, imm, shamt, imem_ready,
    output op_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_field_encode.sv
// Combinational packing of a symbolic LEGv8 instruction into a machine word.
// Range checking is built only when INSTR_ENC_RANGE_CHECK_EN is defined.
module instr_field_encode
  import legv8_pkg::*;
(
  input  logic [3:0]         op_sel,
  input  logic [4:0]         rd,
  input  logic [4:0]         rn,
  input  logic [4:0]         rm,
  input  logic signed [31:0] imm,
  input  logic [5:0]         shamt,
  output logic [31:0]        word,
  output logic               err
);

  always_comb begin
    word = '0;
    case (op_sel)
      OP_ADDI: word = {OPC_ADDI, imm[11:0], rn, rd};
      OP_ADDS: word = {OPC_ADDS, rm, 6'd0, rn, rd};
      OP_SUBS: word = {OPC_SUBS, rm, 6'd0, rn, rd};
      OP_LSL:  word = {OPC_LSL, 5'd0, shamt, rn, rd};
      OP_LSR:  word = {OPC_LSR, 5'd0, shamt, rn, rd};
      OP_MUL:  word = {OPC_MUL, rm, MUL_SHAMT, rn, rd};
      OP_LDUR: word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      OP_B:    word = {OPC_B, imm[25:0]};
      OP_CBZ:  word = {OPC_CBZ, imm[18:0], rd};
      OP_B_LT: word = {OPC_BCOND, imm[18:0], COND_LT};
      default: word = '0;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  // Offsets are signed word counts; ADDI's immediate is unsigned.
  always_comb begin
    err = 1'b0;
    case (op_sel)
      OP_ADDI:                              err = !in_range(imm, 0, IMM12_MAX);
      OP_LDUR, OP_STUR:                     err = !in_range(imm, D_MIN, D_MAX);
      OP_B:                                 err = !in_range(imm, B_MIN, B_MAX);
      OP_CBZ, OP_B_LT:                      err = !in_range(imm, CB_MIN, CB_MAX);
      OP_ADDS, OP_SUBS, OP_LSL, OP_LSR,
      OP_MUL:                               err = 1'b0;
      default:                              err = 1'b1;
    endcase
  end
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:26];
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder / instruction-memory loader: accepts symbolic
// requests, packs them and writes consecutive words. Optional range checks
// are enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              enc_err,
  output logic              addr_wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_e;

  state_e            state;
  logic [31:0]       word_p0;
  logic              err_p0;
  logic              vld_p1;
  logic [31:0]       word_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              accept;
  logic              wr_done;

  // Stage 0: combinational encode of the presented request
  instr_field_encode u_field_encode (
    .op_sel (bus.op_sel),
    .rd     (bus.rd),
    .rn     (bus.rn),
    .rm     (bus.rm),
    .imm    (bus.imm),
    .shamt  (bus.shamt),
    .word   (word_p0),
    .err    (err_p0)
  );

  assign bus.op_ready   = (state == RUN) && (!vld_p1 || bus.imem_ready);
  assign accept         = bus.op_valid && bus.op_ready;
  assign wr_done        = vld_p1 && bus.imem_ready;
  assign bus.imem_we    = vld_p1;
  assign bus.imem_addr  = addr_p1;
  assign bus.imem_wdata = word_p1;

  // Stage 1: output register held until the memory takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      word_p1    <= '0;
      addr_p1    <= '0;
      word_count <= '0;
      done       <= 1'b0;
      enc_err    <= 1'b0;
      addr_wrap  <= 1'b0;
    end else begin
      done    <= 1'b0;
      enc_err <= accept && err_p0;
      if (wr_done) begin
        addr_p1    <= addr_p1 + ADDR_W'(1);
        word_count <= word_count + (ADDR_W + 1)'(1);
        if (&addr_p1) addr_wrap <= 1'b1;
      end
      if (accept && !err_p0) begin
        vld_p1  <= 1'b1;
        word_p1 <= word_p0;
      end else if (wr_done) begin
        vld_p1 <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          addr_p1    <= base_addr;
          word_count <= '0;
          addr_wrap  <= 1'b0;
        end
        RUN: if (accept && bus.op_last) state <= DRAIN;
        DRAIN: if (!vld_p1 || bus.imem_ready) begin
          state <= DONE_ST;
          done  <= 1'b1;
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential LEGv8 instruction encoder and instruction-memory loader. Accepts symbolic instructions (operation select plus register, immediate and shift fields) over a valid/ready stream, range-checks and packs them into 32-bit machine words, and writes them to consecutive instruction-memory word addresses through a stallable write port. It sits between the test/boot loader and the single-cycle CPU's instruction memory and generates the same opcode set the CPU control unit decodes.

## Interface
- ADDR_W, 10, instruction-memory word-address width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; loads write address from base_addr, enters RUN
- base_addr  in  ADDR_W  first word address of the program
- op_valid  in  1  instruction request valid
- op_ready  out  1  encoder can accept request
- op_last  in  1  marks final instruction of the program
- op_sel  in  4  operation, legv8_op_e (ADDI, ADDS, B, B_LT, CBZ, LDUR, LSL, LSR, MUL, STUR, SUBS)
- rd, rn, rm  in  5 each  destination/Rt, first source, second source
- imm  in  32  signed immediate/branch offset in words (ADDI: unsigned)
- shamt  in  6  shift amount (LSL/LSR)
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  one-cycle pulse when last word written
- word_count  out  ADDR_W+1  words written since start
- enc_err  out  1  one-cycle pulse, request dropped (range)
- addr_wrap  out  1  sticky, address wrapped since start

## Operation
- FSM: IDLE -> (start) RUN -> (op_last accepted) DRAIN -> (output register empty) DONE_ST -> IDLE. DONE_ST lasts one cycle and asserts done.
- op_ready = (state==RUN) && (!out_valid || imem_ready). Request accepted on op_valid && op_ready.
- Formats: R [31:21]op,[20:16]rm,[15:10]shamt,[9:5]rn,[4:0]rd: ADDS 0x558, SUBS 0x758, LSL 0x69B, LSR 0x69A (rm=0), MUL 0x4D8 (shamt=6'h1F). I: [31:22]0x244,[21:10]imm12,rn,rd (ADDI). D: [31:21]op,[20:12]addr9,[11:10]00,rn,rt: LDUR 0x7C2, STUR 0x7C0. B: [31:26]0x05,[25:0]imm26. CB: [31:24]op,[23:5]imm19,[4:0]: CBZ 0xB4 with rt, B_LT 0x54 with cond 0xB.
- Ranges: ADDI 0..4095; D -256..255; CB -2^18..2^18-1; B -2^25..2^25-1; shamt 0..63; op_sel outside enum always an error. Offsets truncated to field width two's-complement.
- Erroneous request: accepted (handshake completes), not written, enc_err pulses, word_count unchanged. If it carries op_last, DRAIN still entered.
- Address increments by 1 modulo 2^ADDR_W after each completed write; transition from all-ones to 0 sets addr_wrap.
- start while not IDLE ignored. start in IDLE clears word_count and addr_wrap.

## Timing
- Reset: state IDLE, op_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, word_count 0, enc_err 0, addr_wrap 0. Reset mid-program abandons pending write immediately.
- Latency: accept at cycle N -> imem_we with data at N+1. Throughput one word/cycle with imem_ready high.
- imem_we held, imem_addr/imem_wdata stable until imem_ready; write completes on imem_we && imem_ready.
- Simultaneous completion and new accept in same cycle allowed (output register reloads).
- done pulses the cycle after last write completes; one-cycle start -> op_ready latency.

## Configuration
- INSTR_ENC_RANGE_CHECK_EN defined: range checks above active, errors dropped with enc_err.
- Undefined: no range checks, fields silently truncated, every valid op_sel written; invalid op_sel writes 32'h0; enc_err tied 0.

## Structure
- legv8_pkg: legv8_op_e enum, 11-bit/10-bit/8-bit/6-bit opcode constants, COND_LT, MUL_SHAMT, field-range constants.
- Sub-module instr_field_encode: combinational op_sel+fields -> {word, err}; instr_encoder holds FSM, output register, address and count.

## Test plan
- start base 0; ADDI rd1 rn2 imm5 -> addr 0, wdata 0x91001441 one cycle after accept.
- ADDS rd3 rn1 rm2 then B imm -1 back-to-back -> 0xAB020023 @addr0, 0x17FFFFFF @addr1, consecutive cycles.
- CBZ rt5 imm2, B_LT imm3, LDUR rt4 rn6 imm -8 (last) -> 0xB4000045, 0x5400006B, 0xF85F80C4; done pulse, word_count 3.
- imem_ready low 4 cycles during second write -> imem_we/addr/wdata stable, op_ready 0, no lost/duplicated word.
- ADDI imm 4096 (macro on) -> enc_err pulse, no write, word_count unchanged; macro off -> wdata 0x91000000.
- base 1023, ADDR_W 10, two writes -> addrs 1023 then 0, addr_wrap 1; reset_n low mid-stall -> all outputs to reset values.
